dual_edge_tx: RTL and testbench

Event-to-edge encoder: each accepted event is signalled as one transition (rising or falling) on a single output line. Consecutive transitions are spaced by a guaranteed minimum hold time, so a synchronous dual-edge detector on the far side recovers exactly one pulse per event. Producers hand events in over a valid/ready handshake. Events that have been accepted but not yet signalled are held in a saturating pending counter.

---
 rtl/dual_edge_pkg.sv | 17 +
 rtl/dual_edge_tx.sv | 119 +++++++++++
 tb/tb_dual_edge_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dual_edge_pkg.sv
// dual_edge_pkg: definitions shared by the dual-edge encoder and its receiver.
//   state_e             one-hot FSM encoding (IDLE, HOLD)
//   IDLE_IDX / HOLD_IDX bit positions of each state within state_e
//   HOLD_CYCLES_DEFAULT default minimum spacing between line transitions
package dual_edge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    HOLD = 2'b10
  } state_e;

  localparam int unsigned IDLE_IDX = 0;
  localparam int unsigned HOLD_IDX = 1;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/dual_edge_tx.sv
// dual_edge_tx: event-to-edge encoder. Each accepted event becomes one
// transition of the line output; transitions are spaced by at least
// HOLD_CYCLES clocks. Accepted-but-unsent events wait in a saturating
// pending counter.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   ev_valid  producer offers an event
//   ev_ready  an event can be taken this cycle
//   flush     discard all pending events
//   line      encoded output (registered)
//   edge_sent one-cycle pulse while line holds a fresh value
//   busy      a hold is running or events are pending
//   pending   number of accepted, unsignalled events
module dual_edge_tx
  import dual_edge_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int unsigned DEPTH_W     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               flush,
  output logic               line,
  output logic               edge_sent,
  output logic               busy,
  output logic [DEPTH_W-1:0] pending
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("dual_edge_tx: HOLD_CYCLES must be within 2..255");
  end

  state_e               state_q, state_d;
  logic                 line_q, line_d;
  logic                 edge_q, edge_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [DEPTH_W-1:0]   pend_q, pend_d;
  logic                 fire;
  logic                 accept;
  logic                 has_pend;

  assign has_pend = (pend_q != '0);

  // Only the registered count gates ready, so a slot freed by a fire on
  // this edge is not reusable until the next cycle.
  assign ev_ready = reset_n && !flush && (pend_q != '1);
  assign accept   = ev_valid && ev_ready;

  assign fire = has_pend &&
                (state_q[IDLE_IDX] || (state_q[HOLD_IDX] && (hold_q == '0)));

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    edge_d  = 1'b0;
    hold_d  = hold_q;

    case (state_q)
      IDLE: ;
      HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (!has_pend) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fire) begin
      line_d  = ~line_q;
      edge_d  = 1'b1;
      hold_d  = HW'(HOLD_CYCLES - 1);
      state_d = HOLD;
    end
  end

  // Fire is judged on the pre-flush count, so a due transition still
  // happens on the flush edge; flush only clears what remains.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      case ({accept, fire})
        2'b10:   pend_d = pend_q + 1'b1;
        2'b01:   pend_d = pend_q - 1'b1;
        default: pend_d = pend_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      line_q  <= 1'b0;
      edge_q  <= 1'b0;
      hold_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      edge_q  <= edge_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  assign line      = line_q;
  assign edge_sent = edge_q;
  assign pending   = pend_q;
  assign busy      = (state_q != IDLE) || has_pend;

endmodule

// File: tb/tb_dual_edge_tx.sv
module tb_dual_edge_tx;

  localparam int H    = 3;
  localparam int W    = 2;
  localparam int MAXP = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ev_valid;
  logic         ev_ready;
  logic         flush;
  logic         line;
  logic         edge_sent;
  logic         busy;
  logic [W-1:0] pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: events wait in a count; a transition may be emitted on
  // any edge at least H edges after the previous one.
  int   ecount = 0;
  int   last_t = -1000;
  int   m_pend = 0;
  logic m_line = 1'b0;
  logic m_es   = 1'b0;

  always #5 clk = ~clk;

  dual_edge_tx #(.HOLD_CYCLES(H), .DEPTH_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .flush     (flush),
    .line      (line),
    .edge_sent (edge_sent),
    .busy      (busy),
    .pending   (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_t = -1000;
    m_pend = 0;
    m_line = 1'b0;
    m_es   = 1'b0;
  endtask

  // Called just after a falling edge: drive, check ready, clock, check state.
  task automatic step(input logic v, input logic f);
    logic exp_ready, acc, fire;
    ev_valid = v;
    flush    = f;
    #1;
    exp_ready = !f && (m_pend != MAXP);
    chk("ev_ready", {31'b0, ev_ready}, {31'b0, exp_ready});
    @(posedge clk);
    ecount++;
    acc  = v && exp_ready;
    fire = (m_pend > 0) && (ecount - last_t >= H);
    if (fire) begin
      m_line = ~m_line;
      last_t = ecount;
    end
    m_es   = fire;
    m_pend = f ? 0 : m_pend + int'(acc) - int'(fire);
    @(negedge clk);
    chk("line",      {31'b0, line},      {31'b0, m_line});
    chk("edge_sent", {31'b0, edge_sent}, {31'b0, m_es});
    chk("pending",   32'(pending),       32'(m_pend));
    chk("busy",      {31'b0, busy},      {31'b0, (m_pend != 0) || (ecount - last_t < H)});
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    ev_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("rst_line",     {31'b0, line},      32'd0);
    chk("rst_pending",  32'(pending),       32'd0);
    chk("rst_busy",     {31'b0, busy},      32'd0);
    chk("rst_edge",     {31'b0, edge_sent}, 32'd0);
    chk("rst_ev_ready", {31'b0, ev_ready},  32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, ev_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int   n;
    int   toggles;
    logic start_line;

    reset_n  = 1'b1;
    ev_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);

    // Reset asserted mid-cycle; outputs must clear immediately.
    async_reset();

    // Single event: toggle one edge after acceptance, busy falls H edges later.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("single_line", {31'b0, line}, 32'd1);
    chk("single_edge", {31'b0, edge_sent}, 32'd1);
    n = 1;
    while (busy && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    chk("single_busy_fall", 32'(n), 32'(H + 1));

    // Burst from a clean start: 6 offers yield 5 accepts and 5 toggles.
    async_reset();
    start_line = line;
    toggles = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      toggles += int'(edge_sent);
    end
    n = 0;
    while (busy && n < 40) begin
      step(1'b0, 1'b0);
      toggles += int'(edge_sent);
      n++;
    end
    chk("burst_toggles", 32'(toggles), 32'd5);
    chk("burst_line", {31'b0, line}, {31'b0, ~start_line});
    chk("burst_busy_drain", {31'b0, busy}, 32'd0);

    // Flush while events pend during a hold.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    chk("flush_pre_pend", 32'(pending), 32'd3);
    step(1'b0, 1'b1);
    chk("flush_pend", 32'(pending), 32'd0);
    toggles = 0;
    n = 0;
    while (busy && n < 20) begin
      step(1'b0, 1'b0);
      toggles += int'(edge_sent);
      n++;
    end
    chk("flush_no_toggle", 32'(toggles), 32'd0);

    // Flush together with an offered event: dropped.
    step(1'b1, 1'b1);
    chk("flush_drop", 32'(pending), 32'd0);
    step(1'b0, 1'b0);

    // Reset in HOLD with line high, then one event after release.
    async_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("hold_line_hi", {31'b0, line}, 32'd1);
    async_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("post_rst_toggle", {31'b0, line}, 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0) && (i % 50 < 30), $urandom_range(0, 24) == 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
